// File: rtl/vga_pallette_ctrl.sv
// Double-buffered 16-entry palette: the CPU writes a shadow bank, and a commit copies it into the active bank on the next vblank rise.
// Optional blink support is enabled with `define VGA_PALLETTE_BLINK_EN.
//
// state   | meaning
// IDLE    | no commit outstanding
// PENDING | commit requested, waiting for a vblank rise
// COPY    | copying shadow -> active, COPY_PER_CYC entries per clock
module vga_pallette_ctrl #(
  parameter int COPY_PER_CYC = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_idx,
  input  logic [11:0] wr_rgb,
  input  logic        commit_req,
  output logic        commit_busy,
  input  logic        vblank,
  input  logic        pix_valid,
  input  logic [3:0]  fg,
  input  logic [3:0]  bg,
  input  logic        blink,
  output logic        out_valid,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COPY    = 2'd2
  } state_t;

  localparam logic [3:0] CopyStep = 4'(COPY_PER_CYC);
  localparam logic [3:0] CopyLast = 4'(16 - COPY_PER_CYC);

  state_t      state_q, state_d;
  logic [3:0]  copy_cnt_q, copy_cnt_d;
  logic        rearm_q, rearm_d;
  logic        vblank_q;
  logic        vblank_rise;

  logic [11:0] shadow_q [16];
  logic [11:0] shadow_d [16];
  logic [11:0] active_q [16];
  logic [11:0] active_d [16];

  logic        pix_valid_q;
  logic [3:0]  fg_q, bg_q;
  logic        blink_q;
  logic        out_valid_q;
  logic [7:0]  r_q, g_q, b_q;
  logic [7:0]  r_d, g_d, b_d;
  logic [3:0]  fg_sel;
  logic        wr_fire;

  assign vblank_rise = vblank & ~vblank_q;
  assign wr_ready    = (state_q != S_COPY);
  assign commit_busy = (state_q != S_IDLE);
  assign wr_fire     = wr_valid & wr_ready;
  assign out_valid   = out_valid_q;
  assign R           = r_q;
  assign G           = g_q;
  assign B           = b_q;

  always_comb begin
    state_d    = state_q;
    copy_cnt_d = copy_cnt_q;
    rearm_d    = rearm_q;
    shadow_d   = shadow_q;
    active_d   = active_q;

    if (wr_fire) begin
      shadow_d[wr_idx] = wr_rgb;
    end

    unique case (state_q)
      S_IDLE: begin
        if (commit_req) state_d = S_PENDING;
      end
      S_PENDING: begin
        if (vblank_rise) begin
          state_d    = S_COPY;
          copy_cnt_d = 4'd0;
        end
      end
      S_COPY: begin
        for (int k = 0; k < COPY_PER_CYC; k++) begin
          active_d[copy_cnt_q + 4'(k)] = shadow_q[copy_cnt_q + 4'(k)];
        end
        if (commit_req) rearm_d = 1'b1;
        if (copy_cnt_q == CopyLast) begin
          copy_cnt_d = 4'd0;
          // a request landing on the final copy cycle still counts as a re-arm
          if (rearm_q | commit_req) begin
            state_d = S_PENDING;
            rearm_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          copy_cnt_d = copy_cnt_q + CopyStep;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef VGA_PALLETTE_BLINK_EN
  localparam int FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (vblank_rise) begin
      if (frame_cnt_q == FcW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign fg_sel = (blink_q & blink_phase_q) ? bg_q : fg_q;
`else
  logic unused_blink;
  assign unused_blink = blink_q ^ (BLINK_FRAMES == 0);
  assign fg_sel       = fg_q;
`endif

  // Stage 2 reads the active bank before this edge's copy lands.
  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (pix_valid_q) begin
      r_d = {active_q[fg_sel][11:8], active_q[bg_q][11:8]};
      g_d = {active_q[fg_sel][7:4],  active_q[bg_q][7:4]};
      b_d = {active_q[fg_sel][3:0],  active_q[bg_q][3:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      copy_cnt_q  <= 4'd0;
      rearm_q     <= 1'b0;
      vblank_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      fg_q        <= 4'd0;
      bg_q        <= 4'd0;
      blink_q     <= 1'b0;
      out_valid_q <= 1'b0;
      r_q         <= 8'd0;
      g_q         <= 8'd0;
      b_q         <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 12'(i * 12'h111);
        active_q[i] <= 12'(i * 12'h111);
      end
    end else begin
      state_q     <= state_d;
      copy_cnt_q  <= copy_cnt_d;
      rearm_q     <= rearm_d;
      vblank_q    <= vblank;
      pix_valid_q <= pix_valid;
      fg_q        <= fg;
      bg_q        <= bg;
      blink_q     <= blink;
      out_valid_q <= pix_valid_q;
      r_q         <= r_d;
      g_q         <= g_d;
      b_q         <= b_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

endmodule

// File: doc/vga_pallette_ctrl.md
Name: vga_pallette_ctrl

Overview:
Programmable 16-entry palette controller for the VGA text pipeline. Replaces the fixed grayscale lookup with a double-buffered palette. The CPU side writes a shadow bank through a valid/ready port. A commit request copies the shadow bank into the active bank during the next vertical blank, so palette changes never tear mid-frame. The pixel side issues fg/bg index pairs and receives packed R/G/B bytes after a fixed 2-cycle latency.

Parameters:
COPY_PER_CYC, 1, active-bank entries copied per clock during commit; legal values 1, 2, 4, 8, 16.
BLINK_FRAMES, 32, frames per blink half-period; used only with the optional feature.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  CPU palette write request
wr_ready  output  1  write accepted this cycle when high with wr_valid
wr_idx  input  4  palette entry to write
wr_rgb  input  12  entry value, {R[3:0],G[3:0],B[3:0]}
commit_req  input  1  single-cycle pulse requesting a shadow-to-active copy
commit_busy  output  1  high while a commit is pending or copying
vblank  input  1  vertical blank level from the timing generator
pix_valid  input  1  pixel lookup request
fg  input  4  foreground palette index
bg  input  4  background palette index
blink  input  1  per-character blink attribute; ignored unless blink is enabled
out_valid  output  1  R/G/B valid, 2 cycles after pix_valid
R  output  8  {fg_R[3:0], bg_R[3:0]}
G  output  8  {fg_G[3:0], bg_G[3:0]}
B  output  8  {fg_B[3:0], bg_B[3:0]}

Behaviour:
- Reset (async, rst_n low):
  - Shadow and active entry i both load i*12'h111 (grayscale ramp 0x000..0xFFF).
  - FSM goes to IDLE; copy counter and re-arm flag clear.
  - Outputs: out_valid=0, R=G=B=0, commit_busy=0, wr_ready=1.
- vblank rise detect: vblank is registered once; rise = vblank & ~vblank_q.
- FSM states IDLE, PENDING, COPY:
  - IDLE: commit_req -> PENDING.
  - PENDING: waits for a vblank rise, then -> COPY. If vblank is already high when PENDING is entered, the copy waits for the next frame's rise. commit_req in PENDING is absorbed.
  - COPY: each cycle copies COPY_PER_CYC entries shadow->active, starting at index 0 with the copy counter advancing by COPY_PER_CYC. After index 15 is written: -> PENDING if the re-arm flag is set (flag clears), else -> IDLE.
  - commit_req during COPY sets the re-arm flag.
  - Copy continues even if vblank falls mid-copy; 16/COPY_PER_CYC cycles is far shorter than blanking.
- commit_busy = (state != IDLE).
- Write port:
  - wr_ready = (state != COPY).
  - On wr_valid & wr_ready, shadow[wr_idx] <= wr_rgb at the clock edge.
  - Writes never touch the active bank directly.
  - A write in the same cycle as PENDING->COPY is accepted, and the copy sees the new value.
  - commit_req and an accepted write in the same cycle: the write is included in the commit.
- Pixel pipeline, always ready, no stall:
  - Stage 1 registers pix_valid, fg, bg (and blink).
  - Stage 2 reads active[fg_q] and active[bg_q] and registers R/G/B packed as above.
  - out_valid is pix_valid delayed by 2.
  - When the stage-2 input is not valid, R/G/B hold their previous values.
  - During COPY, a lookup returns the active entry as of the start of that cycle; the new value is visible one cycle after it is copied.
- All state updates occur on the rising edge of clk only.

Optional Feature:
- Macro: VGA_PALLETTE_BLINK_EN.
- When defined:
  - A frame counter increments on each vblank rise, wrapping at BLINK_FRAMES-1.
  - A blink_phase flop toggles on each wrap; it resets to 0.
  - At stage 2, if blink_q & blink_phase, the fg index is replaced by bg_q (the character disappears).
- When undefined:
  - The blink port exists but is ignored.
  - No frame counter or blink_phase is synthesised; the fg lookup always uses fg_q.

Test Plan:
- Reset, then pix_valid with fg=4'hF, bg=4'h0 -> two cycles later out_valid=1, R=G=B=8'hF0.
- Write idx 3 = 12'hA5C with no commit; look up fg=3, bg=3 -> R=G=B=8'h33 (active bank unchanged).
- Commit with vblank low: commit_busy=1 until the vblank rise plus 16 copy cycles (COPY_PER_CYC=1). Then fg=3, bg=0 -> R=8'hA0, G=8'h50, B=8'hC0; wr_ready=0 exactly during the 16 COPY cycles.
- commit_req during COPY -> after COPY the FSM returns to PENDING and copies again at the next vblank rise. commit_req while vblank is already high -> no copy until the next rise.
- Assert rst_n low mid-COPY (counter=7) -> immediately IDLE, commit_busy=0, all entries back to the i*0x111 ramp, out_valid=0.
- With VGA_PALLETTE_BLINK_EN defined and BLINK_FRAMES=2: blink=1, fg=F, bg=0 gives R=8'hF0 for two frames, then 8'h00 for two frames. Without the macro, it gives 8'hF0 always.
